lc3b_mem_arbiter: RTL

Two-client arbiter between the split L1 caches (I-cache, D-cache) and the single shared physical-memory port of the LC-3b pipeline. It issues one cache-line transaction at a time to physical memory and routes the response back to the granted client. Its memory-side handshake (pmem_read, pmem_write, pmem_resp) is exactly what the cache-miss counter monitors, so the two blocks share one handshake definition.

---
 rtl/lc3b_types.sv | 13 +
 rtl/lc3b_mem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: line/word widths and the arbiter's state and memory-op encodings.
package lc3b_types;

    localparam int unsigned LC3B_ADDR_W = 16;
    localparam int unsigned LC3B_LINE_W = 128;

    typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} lc3b_arb_state;
    typedef enum logic {OP_READ, OP_WRITE} lc3b_mem_op;

endpackage

// File: rtl/lc3b_mem_arbiter.sv
// I-cache / D-cache arbiter onto the single physical-memory port, one line transaction at a time.
// Define LC3B_ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache always wins a tie.
module lc3b_mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = $bits(lc3b_word),
    parameter int unsigned LINE_W = $bits(lc3b_c_line)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy
);

    lc3b_arb_state     r_state;
    lc3b_mem_op        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    logic w_d_req;
    logic w_prefer_d;
    logic w_grant_d;
    logic w_grant_i;

`ifdef LC3B_ARB_RR_EN
    // Set when the most recent grant went to the I-cache; reset value hands the first tie to D.
    logic r_last_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_i <= 1'b1;
        end else if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
            r_last_i <= w_grant_i;
        end
    end
`endif

    always_comb begin
        w_d_req = d_mem_read | d_mem_write;
`ifdef LC3B_ARB_RR_EN
        w_prefer_d = r_last_i;
`else
        w_prefer_d = 1'b1;
`endif
        w_grant_d = w_d_req & (~i_mem_read | w_prefer_d);
        w_grant_i = i_mem_read & ~w_grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state <= SERVE_D;
                        // A simultaneous read and write-back from D resolves to the write.
                        r_op    <= d_mem_write ? OP_WRITE : OP_READ;
                        r_addr  <= d_mem_address;
                        r_wdata <= d_mem_wdata;
                    end else if (w_grant_i) begin
                        r_state <= SERVE_I;
                        r_op    <= OP_READ;
                        r_addr  <= i_mem_address;
                        r_wdata <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign arb_busy     = (r_state != IDLE);
    assign pmem_read    = arb_busy && (r_op == OP_READ);
    assign pmem_write   = arb_busy && (r_op == OP_WRITE);
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    assign i_mem_resp  = (r_state == SERVE_I) && pmem_resp;
    assign d_mem_resp  = (r_state == SERVE_D) && pmem_resp;
    assign i_mem_rdata = i_mem_resp ? pmem_rdata : '0;
    assign d_mem_rdata = d_mem_resp ? pmem_rdata : '0;

endmodule
